// File: rtl/ps2_key_decoder.sv
// Pops PS/2 set-2 scan codes from the keyboard FIFO, tracks the held key and press
// count, and drives six active-low hex digits showing code, ASCII and count.
module ps2_key_decoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             ps2_ready,
    input  logic [7:0]       ps2_data,
    output logic             nextdata_n,
    output logic             key_valid,
    output logic             key_ext,
    output logic [7:0]       key_code,
    output logic [7:0]       key_ascii,
    output logic [CNT_W-1:0] key_count,
    output logic [7:0]       seg0,
    output logic [7:0]       seg1,
    output logic [7:0]       seg2,
    output logic [7:0]       seg3,
    output logic [7:0]       seg4,
    output logic [7:0]       seg5
);

    typedef enum logic [1:0] {IDLE, ACK, GAP} state_t;

    state_t     state;
    logic [7:0] byte_q;
    logic       break_pend;
    logic       ext_pend;
    logic       new_press;
    logic [7:0] count8;

    function automatic logic [7:0] scan_to_ascii(input logic [7:0] code);
        case (code)
            8'h1C: return 8'h61;  8'h32: return 8'h62;  8'h21: return 8'h63;
            8'h23: return 8'h64;  8'h24: return 8'h65;  8'h2B: return 8'h66;
            8'h34: return 8'h67;  8'h33: return 8'h68;  8'h43: return 8'h69;
            8'h3B: return 8'h6A;  8'h42: return 8'h6B;  8'h4B: return 8'h6C;
            8'h3A: return 8'h6D;  8'h31: return 8'h6E;  8'h44: return 8'h6F;
            8'h4D: return 8'h70;  8'h15: return 8'h71;  8'h2D: return 8'h72;
            8'h1B: return 8'h73;  8'h2C: return 8'h74;  8'h3C: return 8'h75;
            8'h2A: return 8'h76;  8'h1D: return 8'h77;  8'h22: return 8'h78;
            8'h35: return 8'h79;  8'h1A: return 8'h7A;
            8'h45: return 8'h30;  8'h16: return 8'h31;  8'h1E: return 8'h32;
            8'h26: return 8'h33;  8'h25: return 8'h34;  8'h2E: return 8'h35;
            8'h36: return 8'h36;  8'h3D: return 8'h37;  8'h3E: return 8'h38;
            8'h46: return 8'h39;
            8'h29: return 8'h20;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] hex_font(input logic [3:0] nib);
        case (nib)
            4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
            4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
            4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
            4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
        endcase
    endfunction

    // A make counts only when it names a different key (code or E0 prefix) than the held one.
    assign new_press = !key_valid || (byte_q != key_code) || (ext_pend != key_ext);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            byte_q     <= 8'h00;
            nextdata_n <= 1'b1;
            break_pend <= 1'b0;
            ext_pend   <= 1'b0;
            key_valid  <= 1'b0;
            key_ext    <= 1'b0;
            key_code   <= 8'h00;
            key_ascii  <= 8'h00;
            key_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ps2_ready) begin
                        byte_q     <= ps2_data;
                        nextdata_n <= 1'b0;
                        state      <= ACK;
                    end
                end
                ACK: begin
                    nextdata_n <= 1'b1;
                    state      <= GAP;
                    if (byte_q == 8'hF0) begin
                        break_pend <= 1'b1;
                    end else if (byte_q == 8'hE0) begin
                        ext_pend <= 1'b1;
                    end else if (break_pend) begin
                        if (key_valid && (byte_q == key_code)) begin
                            key_valid <= 1'b0;
                        end
                        break_pend <= 1'b0;
                        ext_pend   <= 1'b0;
                    end else begin
                        if (new_press) begin
                            key_count <= key_count + {{(CNT_W-1){1'b0}}, 1'b1};
                            key_code  <= byte_q;
                            key_ext   <= ext_pend;
                            key_valid <= 1'b1;
                            key_ascii <= ext_pend ? 8'h00 : scan_to_ascii(byte_q);
                        end
                        ext_pend <= 1'b0;
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign count8 = 8'(key_count);

    assign seg0 = key_valid ? hex_font(key_code[3:0])  : 8'hFF;
    assign seg1 = key_valid ? hex_font(key_code[7:4])  : 8'hFF;
    assign seg2 = key_valid ? hex_font(key_ascii[3:0]) : 8'hFF;
    assign seg3 = key_valid ? hex_font(key_ascii[7:4]) : 8'hFF;
    assign seg4 = hex_font(count8[3:0]);
    assign seg5 = hex_font(count8[7:4]);

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Drives ps2_key_decoder from a modelled scan-code FIFO and checks every processed
// byte against a key-tracking reference model.
module tb_ps2_key_decoder;

    logic       clk;
    logic       resetn;
    logic       ps2_ready;
    logic [7:0] ps2_data;
    logic       nextdata_n;
    logic       key_valid;
    logic       key_ext;
    logic [7:0] key_code;
    logic [7:0] key_ascii;
    logic [7:0] key_count;
    logic [7:0] seg0, seg1, seg2, seg3, seg4, seg5;

    ps2_key_decoder #(.CNT_W(8)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .ps2_ready  (ps2_ready),
        .ps2_data   (ps2_data),
        .nextdata_n (nextdata_n),
        .key_valid  (key_valid),
        .key_ext    (key_ext),
        .key_code   (key_code),
        .key_ascii  (key_ascii),
        .key_count  (key_count),
        .seg0       (seg0),
        .seg1       (seg1),
        .seg2       (seg2),
        .seg3       (seg3),
        .seg4       (seg4),
        .seg5       (seg5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int tick = 0;
    int pulses = 0;
    int last_pulse = -1;

    logic [7:0] fifo[$];
    logic [7:0] ascii_of[logic [7:0]];
    logic [7:0] font[16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    logic [7:0] letter_codes[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                     8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                     8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                     8'h35, 8'h1A};
    logic [7:0] digit_codes[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                    8'h3E, 8'h46};
    logic [7:0] pool[8] = '{8'h1C, 8'h32, 8'h45, 8'h29, 8'h15, 8'h16, 8'h5A, 8'h75};

    // Reference model: the key last pressed as {ext,code}, whether it is still held.
    bit         m_held;
    logic [8:0] m_key;
    int         m_count;
    bit         m_brk;
    bit         m_extp;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    function automatic void modelReset();
        m_held  = 1'b0;
        m_key   = 9'h000;
        m_count = 0;
        m_brk   = 1'b0;
        m_extp  = 1'b0;
    endfunction

    function automatic void modelByte(input logic [7:0] b);
        if (b == 8'hF0) m_brk = 1'b1;
        else if (b == 8'hE0) m_extp = 1'b1;
        else if (m_brk) begin
            if (m_held && b == m_key[7:0]) m_held = 1'b0;
            m_brk  = 1'b0;
            m_extp = 1'b0;
        end else begin
            if (!m_held || {m_extp, b} != m_key) begin
                m_count = (m_count + 1) % 256;
                m_key   = {m_extp, b};
                m_held  = 1'b1;
            end
            m_extp = 1'b0;
        end
    endfunction

    task automatic checkModel(input string tag);
        logic [7:0] exp_ascii;
        logic [7:0] cnt8;
        exp_ascii = (m_key[8] || !ascii_of.exists(m_key[7:0])) ? 8'h00 : ascii_of[m_key[7:0]];
        cnt8 = 8'(m_count);
        checkOutput({tag, ".key_valid"}, key_valid, m_held);
        checkOutput({tag, ".key_ext"},   key_ext,   m_key[8]);
        checkOutput({tag, ".key_code"},  key_code,  m_key[7:0]);
        checkOutput({tag, ".key_ascii"}, key_ascii, exp_ascii);
        checkOutput({tag, ".key_count"}, key_count, cnt8);
        checkOutput({tag, ".seg0"}, seg0, m_held ? font[m_key[3:0]] : 8'hFF);
        checkOutput({tag, ".seg1"}, seg1, m_held ? font[m_key[7:4]] : 8'hFF);
        checkOutput({tag, ".seg2"}, seg2, m_held ? font[exp_ascii[3:0]] : 8'hFF);
        checkOutput({tag, ".seg3"}, seg3, m_held ? font[exp_ascii[7:4]] : 8'hFF);
        checkOutput({tag, ".seg4"}, seg4, font[cnt8[3:0]]);
        checkOutput({tag, ".seg5"}, seg5, font[cnt8[7:4]]);
    endtask

    function automatic void updatePins();
        ps2_ready = (fifo.size() != 0);
        ps2_data  = ps2_ready ? fifo[0] : 8'h00;
    endfunction

    task automatic applyStimulus(input logic [7:0] b);
        fifo.push_back(b);
        updatePins();
    endtask

    // Pops a byte whenever the DUT strobes nextdata_n, checking state one cycle later.
    task automatic drainFifo(input string tag);
        int budget;
        int cyc;
        bit chk;
        budget = fifo.size() * 4 + 20;
        cyc = 0;
        chk = 1'b0;
        while ((fifo.size() != 0 || chk) && cyc < budget) begin
            @(negedge clk);
            cyc++;
            tick++;
            if (chk) begin
                checkOutput({tag, ".pulse_width"}, nextdata_n, 1'b1);
                checkModel(tag);
                chk = 1'b0;
            end else if (!nextdata_n) begin
                pulses++;
                if (last_pulse >= 0)
                    checkOutput({tag, ".pulse_gap_ok"}, (tick - last_pulse) >= 3, 1'b1);
                last_pulse = tick;
                if (fifo.size() == 0) begin
                    checkOutput({tag, ".pop_on_empty"}, 1'b1, ps2_ready);
                end else begin
                    modelByte(fifo.pop_front());
                    updatePins();
                    chk = 1'b1;
                end
            end
        end
        checkOutput({tag, ".drain_left"}, fifo.size() + int'(chk), 0);
    endtask

    task automatic doReset();
        resetn = 1'b0;
        fifo.delete();
        updatePins();
        modelReset();
        last_pulse = -1;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        foreach (letter_codes[i]) ascii_of[letter_codes[i]] = 8'h61 + 8'(i);
        foreach (digit_codes[i]) ascii_of[digit_codes[i]] = 8'h30 + 8'(i);
        ascii_of[8'h29] = 8'h20;
        ps2_ready = 1'b0;
        ps2_data  = 8'h00;
        resetn    = 1'b1;
        #2;
        doReset();
        checkOutput("reset.nextdata_n", nextdata_n, 1'b1);
        checkModel("reset");

        // Basic press and release.
        applyStimulus(8'h1C);
        drainFifo("press_a");
        checkOutput("press_a.ascii61", key_ascii, 8'h61);
        checkOutput("press_a.seg1F9", seg1, 8'hF9);
        checkOutput("press_a.seg0C6", seg0, 8'hC6);
        applyStimulus(8'hF0);
        applyStimulus(8'h1C);
        drainFifo("release_a");
        checkOutput("release_a.seg3", seg3, 8'hFF);

        // Typematic repeats must not count and must keep the handshake spacing.
        doReset();
        pulses = 0;
        foreach (pool[i]) if (i < 5) applyStimulus(i < 3 ? 8'h1C : (i == 3 ? 8'hF0 : 8'h1C));
        drainFifo("typematic");
        checkOutput("typematic.pulses", pulses, 5);
        checkOutput("typematic.count", key_count, 8'd1);

        // Extended key; a later plain make of the same code must be non-extended.
        doReset();
        applyStimulus(8'hE0);
        applyStimulus(8'h75);
        drainFifo("ext_press");
        checkOutput("ext_press.key_ext", key_ext, 1'b1);
        checkOutput("ext_press.ascii", key_ascii, 8'h00);
        applyStimulus(8'hE0);
        applyStimulus(8'hF0);
        applyStimulus(8'h75);
        applyStimulus(8'h75);
        drainFifo("ext_release");
        checkOutput("ext_release.plain_ext", key_ext, 1'b0);
        checkOutput("ext_release.count", key_count, 8'd2);

        // Stray break with nothing held.
        doReset();
        applyStimulus(8'hF0);
        applyStimulus(8'h32);
        drainFifo("stray");
        checkOutput("stray.valid", key_valid, 1'b0);
        applyStimulus(8'h32);
        drainFifo("after_stray");
        checkOutput("after_stray.ascii62", key_ascii, 8'h62);

        // Counter wrap over 256 presses.
        doReset();
        for (int i = 0; i < 256; i++) begin
            applyStimulus(8'h45);
            drainFifo("wrap_press");
            if (i == 254) begin
                checkOutput("wrap_ff.seg5", seg5, 8'h8E);
                checkOutput("wrap_ff.seg4", seg4, 8'h8E);
            end
            applyStimulus(8'hF0);
            applyStimulus(8'h45);
            drainFifo("wrap_release");
        end
        checkOutput("wrap_00.seg5", seg5, 8'hC0);
        checkOutput("wrap_00.seg4", seg4, 8'hC0);

        // Randomised make/break/extended traffic.
        doReset();
        for (int i = 0; i < 60; i++) begin
            logic [7:0] k;
            k = pool[$urandom_range(7)];
            if ($urandom_range(3) == 0) applyStimulus(8'hE0);
            if ($urandom_range(2) == 0) applyStimulus(8'hF0);
            applyStimulus(k);
            if ($urandom_range(3) == 0) drainFifo("random");
        end
        drainFifo("random");

        // Asynchronous reset in the middle of a handshake.
        applyStimulus(8'h1C);
        begin
            int waited;
            waited = 0;
            while (nextdata_n && waited < 10) begin
                @(negedge clk);
                waited++;
            end
            checkOutput("async.reached_ack", nextdata_n, 1'b0);
        end
        #1 resetn = 1'b0;
        #1;
        modelReset();
        checkOutput("async.nextdata_n", nextdata_n, 1'b1);
        checkModel("async");
        fifo.delete();
        updatePins();
        last_pulse = -1;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        applyStimulus(8'h15);
        drainFifo("post_reset");
        checkOutput("post_reset.ascii71", key_ascii, 8'h71);
        checkOutput("post_reset.count", key_count, 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Sits directly downstream of ps2_keyboard: pops scan-code bytes from its FIFO through the ready/nextdata_n handshake and parses PS/2 set-2 make, break and extended sequences.
- Tracks the currently held key, its lowercase ASCII value and a count of distinct key presses.
- Drives six active-low 7-segment digits for the seg display path.

Parameters:
- CNT_W, 8, width of the key-press counter; CNT_W=8 is the only supported value because seg4/seg5 show exactly 2 hex digits.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- ps2_ready  in  1  ps2_keyboard FIFO non-empty
- ps2_data  in  8  FIFO head byte, valid while ps2_ready=1
- nextdata_n  out  1  active-low pop strobe to ps2_keyboard
- key_valid  out  1  a key is currently held
- key_ext  out  1  held key was E0-prefixed
- key_code  out  8  scan code of held key
- key_ascii  out  8  lowercase ASCII of held key; 8'h00 if unmapped or extended
- key_count  out  CNT_W  number of distinct presses
- seg0..seg5  out  8 each  active-low digits; bit0=a .. bit6=g, bit7=dp (always 1)

Behaviour:
- Reset (async, resetn=0) values:
  - Outputs: nextdata_n=1, key_valid=0, key_ext=0, key_code=0, key_ascii=0, key_count=0.
  - Internal: break_pend=0, ext_pend=0, FSM in IDLE.
  - An assertion mid-handshake aborts the handshake immediately; nextdata_n returns to 1 without waiting for a clock edge.
- FSM states: IDLE, ACK, GAP. All transitions occur on the rising edge of clk.
  - IDLE: if ps2_ready=1, latch ps2_data into byte_q, register nextdata_n<=0, go to ACK. Otherwise stay in IDLE.
  - ACK: nextdata_n is low for exactly this one cycle. Process byte_q (rules below), register nextdata_n<=1, go to GAP. ps2_ready is ignored in this state.
  - GAP: one idle cycle so the FIFO pointer can settle, then go to IDLE.
  - Throughput: at most one byte per 3 cycles.
  - Latency: key_* outputs update on the edge that leaves ACK, one cycle after the byte is captured.
- Byte processing in ACK, evaluated in this priority order:
  - 8'hF0: set break_pend=1.
  - 8'hE0: set ext_pend=1.
  - Any other byte with break_pend=1 (break):
    - If key_valid=1 and the byte equals key_code, set key_valid=0.
    - Otherwise (release of a key that is not held) leave key_* unchanged.
    - key_code, key_ext and key_ascii keep their last values.
    - Clear break_pend and ext_pend.
  - Any other byte with break_pend=0 (make):
    - New press: key_valid=0, or the byte differs from key_code, or ext_pend differs from key_ext.
      - key_count<=key_count+1, wrapping 255->0.
      - key_code<=byte, key_ext<=ext_pend, key_valid<=1.
      - key_ascii<=lookup(byte) when ext_pend=0; key_ascii<=8'h00 when ext_pend=1.
    - Typematic repeat: same code and same ext while held. No change.
    - Clear ext_pend.
- ASCII lookup (scan code -> character):
  - Letters: 1C a, 32 b, 21 c, 23 d, 24 e, 2B f, 34 g, 33 h, 43 i, 3B j, 42 k, 4B l, 3A m, 31 n, 44 o, 4D p, 15 q, 2D r, 1B s, 2C t, 3C u, 2A v, 1D w, 22 x, 35 y, 1A z.
  - Digits: 45 '0', 16 '1', 1E '2', 26 '3', 25 '4', 2E '5', 36 '6', 3D '7', 3E '8', 46 '9'.
  - 29 -> 8'h20 (space).
  - Every other code -> 8'h00.
- Segment outputs are combinational from the registered state:
  - seg1:seg0 = key_code high:low nibble.
  - seg3:seg2 = key_ascii high:low nibble.
  - seg5:seg4 = key_count high:low nibble.
  - While key_valid=0, seg0..seg3 = 8'hFF (blank); seg4/seg5 are always shown.
- Hex font: 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E.

Test Plan:
- Reset, then FIFO supplies 1C, F0, 1C.
  - After byte 1: key_valid=1, key_code=1C, key_ascii=61, key_count=1, seg1/seg0=F9/C6.
  - After the final byte: key_valid=0 and seg0..seg3=FF.
- Typematic: 1C, 1C, 1C, F0, 1C -> key_count stays 1; nextdata_n pulses low exactly 5 times, each pulse 1 cycle wide and pulses ≥3 cycles apart.
- Extended key: E0, 75, E0, F0, 75 -> after 75: key_ext=1, key_ascii=00, key_count=1; after the final byte: key_valid=0, ext_pend=0.
- Wrap: 256 press/release pairs of key 45 -> key_count wraps to 0 and seg5/seg4=C0/C0; the preceding press showed FF as seg5/seg4=8E/8E.
- Stray break: F0, 32 with no key held -> key_valid stays 0 and key_count is unchanged. A subsequent 32 then gives key_ascii=62.
- Async reset asserted during ACK -> nextdata_n=1 immediately and all outputs return to reset values. After release, a 15 on the FIFO gives key_ascii=71, key_count=1.
